// File: rtl/priority_encoder.sv
// Registered fixed-priority interrupt encoder: reports the lowest-numbered active
// request line and an any-pending flag, one clock after sampling.
module priority_encoder #(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] interrupts,
   output logic [IDX_W-1:0] y,
   output logic             IRQ
);

   logic [IDX_W-1:0] w_idx;
   logic             w_any;
   logic [IDX_W-1:0] r_y;
   logic             r_irq;

   // Walk from the lowest-priority line upward so the lowest set index is the last one written.
   always_comb begin
      w_idx = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (interrupts[i]) begin
            w_idx = IDX_W'(i);
         end
      end
      w_any = |interrupts;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y   <= '0;
         r_irq <= 1'b0;
      end else begin
         r_y   <= w_idx;
         r_irq <= w_any;
      end
   end

   assign y   = r_y;
   assign IRQ = r_irq;

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench for priority_encoder: the driver queues the expected response per
// applied request word, and a monitor checks it just after the sampling edge.
module tb_priority_encoder;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] interrupts;
   logic [1:0]       y;
   logic             IRQ;

   logic [2:0] exp_q[$];
   logic [2:0] exp_now;
   int         n_cmp;
   int         n_err;

   priority_encoder #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .interrupts (interrupts),
      .y          (y),
      .IRQ        (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: index of the lowest set bit, found by isolating it arithmetically.
   function automatic logic [2:0] model(input logic [WIDTH-1:0] v);
      int u;
      int low;
      int idx;
      u = int'(v);
      if (u == 0) return 3'b000;
      low = u & (-u);
      idx = 0;
      while ((1 << idx) != low) idx++;
      return {2'(idx), 1'b1};
   endfunction

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got y=%0d IRQ=%0d, expected y=%0d IRQ=%0d",
                  name, act[2:1], act[0], exp[2:1], exp[0]);
      end
   endtask

   // Apply a word now; outputs must not move until the next rising edge.
   task automatic drive_now(input logic [WIDTH-1:0] v);
      interrupts = v;
      exp_q.push_back(model(v));
      #2;
      check("no_comb_path", {y, IRQ}, exp_now);
      exp_now = model(v);
   endtask

   task automatic drive(input logic [WIDTH-1:0] v);
      @(negedge clk);
      drive_now(v);
   endtask

   // Pulse reset between edges, after the previous result has been checked.
   task automatic mid_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset_mid", {y, IRQ}, 3'b000);
      exp_now = 3'b000;
      #1 rst_n = 1'b1;
   endtask

   // Monitor: one expected response is consumed per sampling edge.
   always begin
      @(posedge clk);
      if (rst_n && exp_q.size() > 0) begin
         logic [2:0] e;
         e = exp_q.pop_front();
         #1;
         check("scoreboard", {y, IRQ}, e);
      end
   end

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      exp_now    = 3'b000;
      rst_n      = 1'b0;
      interrupts = 4'b1111;
      #2;
      check("reset_no_clock", {y, IRQ}, 3'b000);
      repeat (2) @(negedge clk);
      check("reset_held", {y, IRQ}, 3'b000);
      rst_n = 1'b1;
      drive_now(4'b1111);

      for (int v = 0; v < 16; v++) begin
         drive(4'(v));
         drive(4'b0000);
      end

      drive(4'b0000);
      drive(4'b0000);

      drive(4'b1000);
      drive(4'b0100);

      drive(4'b1000);
      drive(4'b1001);
      drive(4'b1000);

      drive(4'b0100);
      mid_reset();
      drive(4'b0100);
      drive(4'b0100);

      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 3) == 0) drive(4'b0000);
         else drive(4'($urandom));
      end

      drive(4'b0000);
      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
      end
      check("final_idle", {y, IRQ}, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
